pc6001_mem_arb: RTL and testbench

- Shares one single-port synchronous byte memory between three requesters:
  - video fetch (VID)
  - Z80 CPU bus (CPU)
  - HPS ioctl ROM/tape download (DL)
- Sits between the PC6001 core and the on-chip RAM/ROM array, in the clk_sys domain.
- Issues at most one memory command per cycle.
- Returns read data to the issuing requester after a fixed latency, using a tagged read pipeline.

---
 rtl/pc6001_mem_pkg.sv | 14 +
 rtl/pc6001_rd_tag_pipe.sv | 30 +++
 rtl/pc6001_mem_arb.sv | 142 ++++++++++++++
 tb/tb_pc6001_mem_arb.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc6001_mem_pkg.sv
// Shared types and constants for the PC6001 memory arbiter.
package pc6001_mem_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned TAG_W  = 2;

    typedef enum logic [TAG_W-1:0] {
        REQ_NONE = 2'd0,
        REQ_VID  = 2'd1,
        REQ_DL   = 2'd2,
        REQ_CPU  = 2'd3
    } req_tag_t;

endpackage

// File: rtl/pc6001_rd_tag_pipe.sv
// Delays the issued-command tag by RD_LAT cycles so it lines up with mem_rdata.
module pc6001_rd_tag_pipe
    import pc6001_mem_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic     clk_sys,
    input  logic     reset_n,
    input  req_tag_t push_tag,
    output req_tag_t pop_tag
);

    req_tag_t stage [RD_LAT];

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                stage[i] <= REQ_NONE;
            end
        end else begin
            stage[0] <= push_tag;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign pop_tag = stage[RD_LAT-1];

endmodule

// File: rtl/pc6001_mem_arb.sv
// Three-way arbiter (video, download, CPU) for one single-port synchronous byte memory,
// with CPU anti-starvation and a tagged read-return pipeline.
module pc6001_mem_arb
    import pc6001_mem_pkg::*;
#(
    parameter int unsigned AW           = 16,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [AW-1:0]     vid_addr,
    output logic              vid_ack,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dl_active,
    input  logic              dl_req,
    input  logic [AW-1:0]     dl_addr,
    input  logic [DATA_W-1:0] dl_wdata,
    output logic              dl_ack,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_nxt;
    logic              vid_elig;
    logic              dl_elig;
    logic              cpu_elig;
    req_tag_t          grant;
    req_tag_t          cmd_tag;
    req_tag_t          pop_tag;
    logic [DATA_W-1:0] vid_hold;
    logic [DATA_W-1:0] cpu_hold;

    // A requester acked this cycle is still holding req; masking it avoids a double grant.
    always_comb begin
        vid_elig = vid_req && !vid_ack;
        dl_elig  = dl_req  && !dl_ack;
        cpu_elig = cpu_req && !cpu_ack && !dl_active;
    end

    // Winner selection and starvation counter update.
    always_comb begin
        grant      = REQ_NONE;
        starve_nxt = starve_cnt;
        if (cpu_elig && (starve_cnt == CNT_W'(STARVE_LIMIT))) begin
            grant = REQ_CPU;
        end else if (vid_elig) begin
            grant = REQ_VID;
        end else if (dl_elig) begin
            grant = REQ_DL;
        end else if (cpu_elig) begin
            grant = REQ_CPU;
        end

        if (!cpu_elig || (grant == REQ_CPU)) begin
            starve_nxt = '0;
        end else if ((grant != REQ_NONE) && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
            starve_nxt = starve_cnt + CNT_W'(1);
        end
    end

    // Registered grant: ack, memory command and read tag all appear one cycle after sampling.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            vid_ack    <= 1'b0;
            dl_ack     <= 1'b0;
            cpu_ack    <= 1'b0;
            mem_ce     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            starve_cnt <= '0;
            cmd_tag    <= REQ_NONE;
        end else begin
            vid_ack    <= (grant == REQ_VID);
            dl_ack     <= (grant == REQ_DL);
            cpu_ack    <= (grant == REQ_CPU);
            mem_ce     <= (grant != REQ_NONE);
            starve_cnt <= starve_nxt;
            cmd_tag    <= ((grant == REQ_VID) || ((grant == REQ_CPU) && !cpu_we)) ? grant : REQ_NONE;
            case (grant)
                REQ_VID: begin
                    mem_we   <= 1'b0;
                    mem_addr <= vid_addr;
                end
                REQ_DL: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= dl_addr;
                    mem_wdata <= dl_wdata;
                end
                REQ_CPU: begin
                    mem_we    <= cpu_we;
                    mem_addr  <= cpu_addr;
                    mem_wdata <= cpu_wdata;
                end
                default: ;
            endcase
        end
    end

    pc6001_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .push_tag (cmd_tag),
        .pop_tag  (pop_tag)
    );

    assign vid_rvalid = (pop_tag == REQ_VID);
    assign cpu_rvalid = (pop_tag == REQ_CPU);

    // Last returned byte per requester, held between returns.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            vid_hold <= '0;
            cpu_hold <= '0;
        end else begin
            if (vid_rvalid) vid_hold <= mem_rdata;
            if (cpu_rvalid) cpu_hold <= mem_rdata;
        end
    end

    assign vid_rdata = vid_rvalid ? mem_rdata : vid_hold;
    assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_hold;

endmodule

// File: tb/tb_pc6001_mem_arb.sv
// Bench for pc6001_mem_arb: directed scenarios plus random traffic against a rule-level model.
module tb_pc6001_mem_arb;

    localparam int unsigned AW     = 16;
    localparam int unsigned RD_LAT = 3;
    localparam int unsigned LIM    = 8;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        vid_req, vid_ack, vid_rvalid;
    logic [15:0] vid_addr;
    logic [7:0]  vid_rdata;
    logic        cpu_req, cpu_we, cpu_ack, cpu_rvalid;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        dl_active, dl_req, dl_ack;
    logic [15:0] dl_addr;
    logic [7:0]  dl_wdata;
    logic        mem_ce, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    pc6001_mem_arb #(.AW(AW), .RD_LAT(RD_LAT), .STARVE_LIMIT(LIM)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dl_active(dl_active), .dl_req(dl_req), .dl_addr(dl_addr), .dl_wdata(dl_wdata),
        .dl_ack(dl_ack),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk_sys = ~clk_sys;

    // Synchronous memory with RD_LAT read latency; garbage on the bus when no read is due.
    bit [7:0] mem [0:65535];
    bit [7:0] rdp [RD_LAT];
    always @(posedge clk_sys) begin
        if (mem_ce && mem_we) mem[mem_addr] <= mem_wdata;
        rdp[0] <= (mem_ce && !mem_we) ? mem[mem_addr] : 8'($urandom);
        for (int i = 1; i < int'(RD_LAT); i++) rdp[i] <= rdp[i-1];
    end
    assign mem_rdata = rdp[RD_LAT-1];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: arbitration rules, shadow memory, queue of pending read returns.
    typedef struct { int due; bit is_cpu; bit [7:0] d; } rd_t;
    rd_t         rq [$];
    rd_t         r;
    bit [7:0]    sh [0:65535];
    bit          m_vack, m_dack, m_cack, m_ce, m_we;
    logic [15:0] m_addr = '0;
    logic [7:0]  m_wdata = '0;
    logic [7:0]  x_vd = '0, x_cd = '0;
    bit          x_vv, x_cv, el_v, el_d, el_c;
    int          starve = 0;
    int          win;

    always @(negedge clk_sys) begin
        cyc++;
        chk("vid_ack", 32'(vid_ack), 32'(m_vack));
        chk("dl_ack", 32'(dl_ack), 32'(m_dack));
        chk("cpu_ack", 32'(cpu_ack), 32'(m_cack));
        chk("mem_ce", 32'(mem_ce), 32'(m_ce));
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        x_vv = 1'b0;
        x_cv = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            if (r.is_cpu) begin x_cv = 1'b1; x_cd = r.d; end
            else          begin x_vv = 1'b1; x_vd = r.d; end
        end
        chk("vid_rvalid", 32'(vid_rvalid), 32'(x_vv));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(x_cv));
        chk("vid_rdata", 32'(vid_rdata), 32'(x_vd));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(x_cd));

        if (!reset_n) begin
            {m_vack, m_dack, m_cack, m_ce, m_we} = '0;
            m_addr = '0; m_wdata = '0; x_vd = '0; x_cd = '0;
            starve = 0;
            rq.delete();
        end else begin
            el_v = vid_req && !m_vack;
            el_d = dl_req && !m_dack;
            el_c = cpu_req && !m_cack && !dl_active;
            win = 0;
            if (el_c && starve == int'(LIM)) win = 3;
            else if (el_v) win = 1;
            else if (el_d) win = 2;
            else if (el_c) win = 3;
            if (win == 3 || !el_c) starve = 0;
            else if (win != 0) starve = (starve < int'(LIM)) ? starve + 1 : int'(LIM);
            m_vack = (win == 1);
            m_dack = (win == 2);
            m_cack = (win == 3);
            m_ce   = (win != 0);
            case (win)
                1: begin
                    m_we = 1'b0; m_addr = vid_addr;
                    rq.push_back('{cyc + 1 + int'(RD_LAT), 1'b0, sh[vid_addr]});
                end
                2: begin
                    m_we = 1'b1; m_addr = dl_addr; m_wdata = dl_wdata;
                    sh[dl_addr] = dl_wdata;
                end
                3: begin
                    m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata;
                    if (cpu_we) sh[cpu_addr] = cpu_wdata;
                    else rq.push_back('{cyc + 1 + int'(RD_LAT), 1'b1, sh[cpu_addr]});
                end
                default: ;
            endcase
        end
    end

    // Stimulus helpers; the random agents run only while auto_on is set.
    bit       auto_on = 1'b0;
    bit [7:0] dlw [256];

    function automatic logic [15:0] rand_addr();
        return ($urandom_range(0, 3) == 0 ? 16'h4000 : 16'h0000) | 16'($urandom_range(0, 31));
    endfunction

    task automatic step();
        @(posedge clk_sys);
        #1;
        if (auto_on) begin
            if (!reset_n) reset_n = 1'b1;
            else if ($urandom_range(0, 799) == 0) reset_n = 1'b0;
            if ($urandom_range(0, 63) == 0) dl_active = !dl_active;
            if (vid_ack || !vid_req) begin
                vid_req = ($urandom_range(0, 2) != 0); vid_addr = rand_addr();
            end
            if (dl_ack || !dl_req) begin
                dl_req = ($urandom_range(0, 2) == 0); dl_addr = rand_addr();
                dl_wdata = 8'($urandom);
            end
            if (cpu_ack || !cpu_req) begin
                cpu_req = ($urandom_range(0, 1) != 0); cpu_we = 1'($urandom);
                cpu_addr = rand_addr(); cpu_wdata = 8'($urandom);
            end
        end
    endtask

    function automatic bit sig(input int w);
        case (w)
            0:       return vid_ack;
            1:       return dl_ack;
            2:       return cpu_ack;
            3:       return cpu_rvalid;
            default: return vid_rvalid;
        endcase
    endfunction

    task automatic wait_for(input int w, input string nm);
        int i = 0;
        do begin step(); i++; end while (!sig(w) && i < 20);
        chk(nm, 32'(sig(w)), 32'd1);
    endtask

    initial begin
        int tv, td, tc, trv, n, k, nrv, tvr, tcr;
        logic [7:0] cd, vd;
        reset_n = 1'b0; dl_active = 1'b0;
        vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dl_req = 1'b0; dl_addr = '0; dl_wdata = '0;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (2) step();

        // Reset flushes an in-flight video read.
        vid_req = 1'b1; vid_addr = 16'h1234;
        wait_for(0, "t1_vid_ack");
        vid_req = 1'b0;
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("t1_rst_ctrl", 32'({vid_ack, dl_ack, cpu_ack, mem_ce, mem_we, vid_rvalid, cpu_rvalid}), 32'd0);
        chk("t1_rst_addr", 32'(mem_addr), 32'd0);
        chk("t1_rst_wdata", 32'(mem_wdata), 32'd0);
        chk("t1_rst_rdata", 32'({vid_rdata, cpu_rdata}), 32'd0);
        nrv = 0;
        repeat (RD_LAT + 3) begin step(); nrv += int'(vid_rvalid); end
        chk("t1_no_vid_rvalid", 32'(nrv), 32'd0);

        // Simultaneous requests: VID, DL, CPU on consecutive cycles; DL data read back by CPU.
        vid_req = 1'b1; vid_addr = 16'h0100;
        dl_req = 1'b1; dl_addr = 16'h8000; dl_wdata = 8'h3C;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8000;
        tv = -1; td = -1; tc = -1; trv = -1; cd = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (vid_ack) begin tv = i; vid_req = 1'b0; end
            if (dl_ack) begin td = i; dl_req = 1'b0; end
            if (cpu_ack) begin tc = i; cpu_req = 1'b0; end
            if (cpu_rvalid) begin trv = i; cd = cpu_rdata; end
        end
        chk("t2_vid_first", 32'(tv), 32'd0);
        chk("t2_dl_second", 32'(td), 32'(tv + 1));
        chk("t2_cpu_third", 32'(tc), 32'(tv + 2));
        chk("t2_cpu_rd_lat", 32'(trv), 32'(tc + int'(RD_LAT)));
        chk("t2_cpu_rdata", 32'(cd), 32'h3C);

        // Starvation: CPU forced after LIM back-to-back VID/DL grants.
        vid_req = 1'b1; vid_addr = 16'h0300;
        dl_req = 1'b1; dl_addr = 16'h0301; dl_wdata = 8'h11;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0301;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (cpu_ack) break;
            if (vid_ack || dl_ack) n++;
        end
        chk("t3_cpu_acked", 32'(cpu_ack), 32'd1);
        chk("t3_grants_before_cpu", 32'(n), 32'(LIM));
        cpu_req = 1'b0;
        repeat (4) step();
        vid_req = 1'b0; dl_req = 1'b0;
        repeat (RD_LAT + 3) step();

        // Download session blocks the CPU; CPU is served right after it ends.
        dl_active = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
        n = 0; k = 0;
        for (int a = 0; a < 256; a++) begin
            dl_addr = 16'(a); dlw[a] = 8'($urandom); dl_wdata = dlw[a]; dl_req = 1'b1;
            nrv = 0;
            do begin step(); nrv++; n += int'(cpu_ack); end while (!dl_ack && nrv < 10);
            if (!dl_ack) k++;
        end
        dl_req = 1'b0; dl_active = 1'b0;
        chk("t4_dl_timeouts", 32'(k), 32'd0);
        chk("t4_cpu_ack_in_session", 32'(n), 32'd0);
        k = 0;
        do begin step(); k++; end while (!cpu_ack && k < 5);
        cpu_req = 1'b0;
        chk("t4_cpu_ack_within2", 32'(k <= 2 && cpu_ack), 32'd1);
        repeat (RD_LAT + 3) step();

        // Interleaved VID and CPU reads return in issue order with their own data.
        vid_req = 1'b1; vid_addr = 16'h0010;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
        tvr = -1; tcr = -1; vd = '0; cd = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (vid_ack) vid_req = 1'b0;
            if (cpu_ack) cpu_req = 1'b0;
            if (vid_rvalid) begin tvr = i; vd = vid_rdata; end
            if (cpu_rvalid) begin tcr = i; cd = cpu_rdata; end
        end
        chk("t5_vid_rvalid_at", 32'(tvr), 32'(RD_LAT));
        chk("t5_cpu_follows_vid", 32'(tcr), 32'(tvr + 1));
        chk("t5_vid_rdata", 32'(vd), 32'(dlw[16]));
        chk("t5_cpu_rdata", 32'(cd), 32'(dlw[32]));

        // CPU write then read-back of the same address.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4000; cpu_wdata = 8'hA5;
        wait_for(2, "t6_wr_ack");
        chk("t6_mem_we", 32'({mem_ce, mem_we}), 32'd3);
        chk("t6_mem_wdata", 32'(mem_wdata), 32'hA5);
        chk("t6_mem_addr", 32'(mem_addr), 32'h4000);
        cpu_req = 1'b0;
        nrv = 0;
        repeat (RD_LAT + 2) begin step(); nrv += int'(cpu_rvalid); end
        chk("t6_no_rvalid_on_write", 32'(nrv), 32'd0);
        cpu_req = 1'b1; cpu_we = 1'b0;
        wait_for(2, "t6_rd_ack");
        cpu_req = 1'b0;
        wait_for(3, "t6_rd_rvalid");
        chk("t6_readback", 32'(cpu_rdata), 32'hA5);

        // Random traffic with dl_active toggling and occasional resets.
        auto_on = 1'b1;
        repeat (4000) step();
        auto_on = 1'b0;
        reset_n = 1'b1; vid_req = 1'b0; dl_req = 1'b0; cpu_req = 1'b0; dl_active = 1'b0;
        repeat (RD_LAT + 5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
